// File: rtl/fdd_track_sequencer_if.sv
// SD host sector port shared by the track sequencer (master) and SD host (slave).
interface fdd_track_sequencer_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );
endinterface

// File: rtl/fdd_track_sequencer.sv
// Floppy track buffer sequencer: writes back dirty sectors of the old track,
// then loads every sector of the new track over SD channel 0.
module fdd_track_sequencer #(
    parameter int SPT   = 13,
    parameter int SEC_W = 4
) (
    input  logic                  CLK_VIDEO,
    input  logic                  reset,
    input  logic [5:0]            track,
    input  logic                  img_mounted,
    input  logic                  img_present,
    input  logic                  img_readonly,
    input  logic                  fd_write_disk,
    input  logic [13:0]           fd_track_addr,
    fdd_track_sequencer_if.master sd,
    output logic [SEC_W-1:0]      track_sec,
    output logic                  cpu_wait,
    output logic [SPT-1:0]        dirty
);
    typedef enum logic [2:0] {
        IDLE, WB_REQ, WB_XFER, RD_REQ, RD_XFER
    } state_t;

    state_t           state, state_n;
    logic [5:0]       cur_track, cur_track_n;
    logic [5:0]       ld_track, ld_track_n;
    logic [5:0]       wb_track, wb_track_n;
    logic [SEC_W-1:0] sec, sec_n, track_sec_n, low_idx;
    logic [31:0]      lba_n;
    logic             rd_n, wr_n, cpu_wait_n;
    logic             loaded, loaded_n;
    logic             mnt_pend, mnt_pend_n;
    logic             old_ack, rise, fall;
    logic             mount, trigger;
    logic [SPT-1:0]   dirty_n, wr_mask, cur_mask;
    logic             unused_addr;

    assign unused_addr = ^fd_track_addr[8:0];

    assign rise    = ~old_ack & sd.sd_ack;
    assign fall    = old_ack & ~sd.sd_ack;
    assign mount   = img_mounted | mnt_pend;
    assign trigger = ((track != cur_track) && loaded) || mount;

    function automatic logic [31:0] lba_of(
        input logic [5:0]       t,
        input logic [SEC_W-1:0] s
    );
        return 32'(SPT) * {26'd0, t} + {{(32-SEC_W){1'b0}}, s};
    endfunction

    // Sector decode: slots >= SPT and the upper half (bit 13) never match.
    always_comb begin
        low_idx  = '0;
        wr_mask  = '0;
        cur_mask = '0;
        for (int i = SPT - 1; i >= 0; i--) begin
            if (dirty[i])
                low_idx = SEC_W'(i);
        end
        for (int i = 0; i < SPT; i++) begin
            wr_mask[i]  = fd_write_disk && !fd_track_addr[13]
                          && (fd_track_addr[12:9] == 4'(i));
            cur_mask[i] = (track_sec == SEC_W'(i));
        end
    end

    always_comb begin
        state_n     = state;
        cur_track_n = cur_track;
        ld_track_n  = ld_track;
        wb_track_n  = wb_track;
        sec_n       = sec;
        track_sec_n = track_sec;
        lba_n       = sd.sd_lba;
        rd_n        = sd.sd_rd;
        wr_n        = sd.sd_wr;
        cpu_wait_n  = cpu_wait;
        loaded_n    = loaded;
        dirty_n     = dirty;
        mnt_pend_n  = mnt_pend | img_mounted;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    mnt_pend_n  = 1'b0;
                    ld_track_n  = track;
                    cur_track_n = track;
                    wb_track_n  = cur_track;
                    sec_n       = '0;
                    if (!img_present) begin
                        loaded_n = 1'b0;
                        dirty_n  = '0;
                    end else begin
                        cpu_wait_n = 1'b1;
                        if (mount) begin
                            dirty_n = '0;
                            state_n = RD_REQ;
                        end else if (|dirty) begin
                            state_n = WB_REQ;
                        end else begin
                            state_n = RD_REQ;
                        end
                    end
                end else if (loaded && !img_readonly) begin
                    dirty_n = dirty | wr_mask;
                end
            end
            WB_REQ: begin
                lba_n       = lba_of(wb_track, low_idx);
                track_sec_n = low_idx;
                wr_n        = 1'b1;
                state_n     = WB_XFER;
            end
            WB_XFER: begin
                if (rise)
                    wr_n = 1'b0;
                if (fall) begin
                    wr_n    = 1'b0;
                    dirty_n = dirty & ~cur_mask;
                    if ((dirty & ~cur_mask) == '0) begin
                        sec_n   = '0;
                        state_n = RD_REQ;
                    end else begin
                        state_n = WB_REQ;
                    end
                end
            end
            RD_REQ: begin
                lba_n       = lba_of(ld_track, sec);
                track_sec_n = sec;
                rd_n        = 1'b1;
                state_n     = RD_XFER;
            end
            RD_XFER: begin
                if (rise)
                    rd_n = 1'b0;
                if (fall) begin
                    rd_n = 1'b0;
                    if (sec == SEC_W'(SPT - 1)) begin
                        loaded_n   = 1'b1;
                        cpu_wait_n = 1'b0;
                        state_n    = IDLE;
                    end else begin
                        sec_n   = sec + SEC_W'(1);
                        state_n = RD_REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            state     <= IDLE;
            cur_track <= '0;
            ld_track  <= '0;
            wb_track  <= '0;
            sec       <= '0;
            track_sec <= '0;
            sd.sd_lba <= '0;
            sd.sd_rd  <= 1'b0;
            sd.sd_wr  <= 1'b0;
            cpu_wait  <= 1'b0;
            loaded    <= 1'b0;
            dirty     <= '0;
            mnt_pend  <= 1'b0;
            old_ack   <= 1'b0;
        end else begin
            state     <= state_n;
            cur_track <= cur_track_n;
            ld_track  <= ld_track_n;
            wb_track  <= wb_track_n;
            sec       <= sec_n;
            track_sec <= track_sec_n;
            sd.sd_lba <= lba_n;
            sd.sd_rd  <= rd_n;
            sd.sd_wr  <= wr_n;
            cpu_wait  <= cpu_wait_n;
            loaded    <= loaded_n;
            dirty     <= dirty_n;
            mnt_pend  <= mnt_pend_n;
            old_ack   <= sd.sd_ack;
        end
    end
endmodule

// File: tb/tb_fdd_track_sequencer.sv
// Directed bench for fdd_track_sequencer: a small SD host answers each
// request and every scenario task compares against hand-computed values.
module tb_fdd_track_sequencer;
    logic        CLK_VIDEO = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  track = '0;
    logic        img_mounted = 1'b0;
    logic        img_present = 1'b0;
    logic        img_readonly = 1'b0;
    logic        fd_write_disk = 1'b0;
    logic [13:0] fd_track_addr = '0;
    logic [3:0]  track_sec;
    logic        cpu_wait;
    logic [12:0] dirty;

    int n_cmp = 0;
    int n_bad = 0;

    logic        r_wr;
    logic [31:0] r_lba;
    logic [3:0]  r_sec;
    logic        r_wt;
    bit          r_to;

    fdd_track_sequencer_if sd ();

    fdd_track_sequencer #(.SPT(13), .SEC_W(4)) dut (
        .CLK_VIDEO     (CLK_VIDEO),
        .reset         (reset),
        .track         (track),
        .img_mounted   (img_mounted),
        .img_present   (img_present),
        .img_readonly  (img_readonly),
        .fd_write_disk (fd_write_disk),
        .fd_track_addr (fd_track_addr),
        .sd            (sd),
        .track_sec     (track_sec),
        .cpu_wait      (cpu_wait),
        .dirty         (dirty)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    // Waits (bounded) for a request, records it, then acks for 3 cycles.
    task automatic serve();
        int n = 0;
        r_to = 0;
        while (!(sd.sd_rd || sd.sd_wr) && n < 200) begin
            @(negedge CLK_VIDEO);
            n++;
        end
        if (!(sd.sd_rd || sd.sd_wr)) begin
            r_to = 1;
            r_wr = 0; r_lba = '0; r_sec = '0; r_wt = 0;
            return;
        end
        r_wr  = sd.sd_wr;
        r_lba = sd.sd_lba;
        r_sec = track_sec;
        r_wt  = cpu_wait;
        sd.sd_ack = 1'b1;
        repeat (3) @(negedge CLK_VIDEO);
        sd.sd_ack = 1'b0;
    endtask

    task automatic write_sec(input logic [13:0] addr);
        fd_track_addr = addr;
        fd_write_disk = 1'b1;
        @(negedge CLK_VIDEO);
        fd_write_disk = 1'b0;
    endtask

    task automatic pulse_mount();
        img_mounted = 1'b1;
        @(negedge CLK_VIDEO);
        img_mounted = 1'b0;
    endtask

    task automatic test_reset();
        sd.sd_ack = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge CLK_VIDEO);
        n_cmp++; if (sd.sd_lba !== 32'd0) begin n_bad++; $display("FAIL reset_lba got %0d want 0", sd.sd_lba); end
        n_cmp++; if (sd.sd_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd got %0b want 0", sd.sd_rd); end
        n_cmp++; if (sd.sd_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr got %0b want 0", sd.sd_wr); end
        n_cmp++; if (track_sec !== 4'd0) begin n_bad++; $display("FAIL reset_sec got %0d want 0", track_sec); end
        n_cmp++; if (cpu_wait !== 1'b0) begin n_bad++; $display("FAIL reset_wait got %0b want 0", cpu_wait); end
        n_cmp++; if (dirty !== 13'd0) begin n_bad++; $display("FAIL reset_dirty got %h want 0", dirty); end
        reset = 1'b0;
        @(negedge CLK_VIDEO);
    endtask

    task automatic test_mount_load();
        track = 6'd0;
        img_present = 1'b1;
        pulse_mount();
        for (int i = 0; i < 13; i++) begin
            serve();
            n_cmp++;
            if (r_to || r_wr !== 1'b0 || r_lba !== 32'(i) || r_sec !== 4'(i) || r_wt !== 1'b1) begin
                n_bad++;
                $display("FAIL mount_rd[%0d] to=%0b wr=%0b lba=%0d sec=%0d wait=%0b want wr=0 lba=%0d sec=%0d wait=1",
                         i, r_to, r_wr, r_lba, r_sec, r_wt, i, i);
            end
        end
        @(negedge CLK_VIDEO);
        n_cmp++; if (cpu_wait !== 1'b0) begin n_bad++; $display("FAIL mount_wait_end got %0b want 0", cpu_wait); end
        n_cmp++; if (dirty !== 13'd0) begin n_bad++; $display("FAIL mount_dirty got %h want 0", dirty); end
    endtask

    task automatic test_spurious_ack();
        bit seen = 0;
        sd.sd_ack = 1'b1;
        repeat (2) @(negedge CLK_VIDEO);
        sd.sd_ack = 1'b0;
        repeat (6) begin
            @(negedge CLK_VIDEO);
            if (sd.sd_rd || sd.sd_wr || cpu_wait) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL spurious_ack got activity=%0b want 0", seen); end
    endtask

    task automatic test_writeback();
        track = 6'd3;
        for (int i = 0; i < 13; i++) begin
            serve();
            n_cmp++;
            if (r_to || r_wr !== 1'b0 || r_lba !== 32'(39 + i)) begin
                n_bad++;
                $display("FAIL wb_load3[%0d] to=%0b wr=%0b lba=%0d want wr=0 lba=%0d", i, r_to, r_wr, r_lba, 39 + i);
            end
        end
        repeat (2) @(negedge CLK_VIDEO);
        write_sec(14'h0A00);
        write_sec(14'h1800);
        write_sec(14'h1A00);
        write_sec(14'h2400);
        @(negedge CLK_VIDEO);
        n_cmp++; if (dirty !== 13'h1020) begin n_bad++; $display("FAIL wb_dirty_mask got %h want 1020", dirty); end
        track = 6'd4;
        serve();
        n_cmp++;
        if (r_to || r_wr !== 1'b1 || r_lba !== 32'd44 || r_sec !== 4'd5) begin
            n_bad++;
            $display("FAIL wb_first to=%0b wr=%0b lba=%0d sec=%0d want wr=1 lba=44 sec=5", r_to, r_wr, r_lba, r_sec);
        end
        serve();
        n_cmp++;
        if (r_to || r_wr !== 1'b1 || r_lba !== 32'd51 || r_sec !== 4'd12) begin
            n_bad++;
            $display("FAIL wb_second to=%0b wr=%0b lba=%0d sec=%0d want wr=1 lba=51 sec=12", r_to, r_wr, r_lba, r_sec);
        end
        for (int i = 0; i < 13; i++) begin
            serve();
            n_cmp++;
            if (r_to || r_wr !== 1'b0 || r_lba !== 32'(52 + i) || r_sec !== 4'(i)) begin
                n_bad++;
                $display("FAIL wb_load4[%0d] to=%0b wr=%0b lba=%0d sec=%0d want wr=0 lba=%0d sec=%0d",
                         i, r_to, r_wr, r_lba, r_sec, 52 + i, i);
            end
        end
        @(negedge CLK_VIDEO);
        n_cmp++; if (dirty !== 13'd0) begin n_bad++; $display("FAIL wb_dirty_end got %h want 0", dirty); end
        n_cmp++; if (cpu_wait !== 1'b0) begin n_bad++; $display("FAIL wb_wait_end got %0b want 0", cpu_wait); end
    endtask

    task automatic test_readonly();
        track = 6'd1;
        for (int i = 0; i < 13; i++) begin
            serve();
            n_cmp++;
            if (r_to || r_wr !== 1'b0 || r_lba !== 32'(13 + i)) begin
                n_bad++;
                $display("FAIL ro_load1[%0d] to=%0b wr=%0b lba=%0d want wr=0 lba=%0d", i, r_to, r_wr, r_lba, 13 + i);
            end
        end
        repeat (2) @(negedge CLK_VIDEO);
        img_readonly = 1'b1;
        write_sec(14'h0400);
        @(negedge CLK_VIDEO);
        n_cmp++; if (dirty !== 13'd0) begin n_bad++; $display("FAIL ro_dirty got %h want 0", dirty); end
        track = 6'd2;
        for (int i = 0; i < 13; i++) begin
            serve();
            n_cmp++;
            if (r_to || r_wr !== 1'b0 || r_lba !== 32'(26 + i)) begin
                n_bad++;
                $display("FAIL ro_load2[%0d] to=%0b wr=%0b lba=%0d want wr=0 lba=%0d", i, r_to, r_wr, r_lba, 26 + i);
            end
        end
        repeat (2) @(negedge CLK_VIDEO);
        img_readonly = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit moved = 0;
        track = 6'd6;
        for (int i = 0; i < 6; i++) begin
            serve();
            n_cmp++;
            if (r_to || r_lba !== 32'(78 + i)) begin
                n_bad++;
                $display("FAIL rst_load6[%0d] to=%0b lba=%0d want %0d", i, r_to, r_lba, 78 + i);
            end
        end
        while (!sd.sd_rd && n < 200) begin
            @(negedge CLK_VIDEO);
            n++;
        end
        n_cmp++;
        if (sd.sd_rd !== 1'b1 || sd.sd_lba !== 32'd84 || track_sec !== 4'd6) begin
            n_bad++;
            $display("FAIL rst_req6 rd=%0b lba=%0d sec=%0d want rd=1 lba=84 sec=6", sd.sd_rd, sd.sd_lba, track_sec);
        end
        sd.sd_ack = 1'b1;
        reset = 1'b1;
        @(negedge CLK_VIDEO);
        reset = 1'b0;
        n_cmp++; if (sd.sd_rd !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rd got %0b want 0", sd.sd_rd); end
        n_cmp++; if (sd.sd_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mid_wr got %0b want 0", sd.sd_wr); end
        n_cmp++; if (cpu_wait !== 1'b0) begin n_bad++; $display("FAIL rst_mid_wait got %0b want 0", cpu_wait); end
        n_cmp++; if (track_sec !== 4'd0) begin n_bad++; $display("FAIL rst_mid_sec got %0d want 0", track_sec); end
        n_cmp++; if (sd.sd_lba !== 32'd0) begin n_bad++; $display("FAIL rst_mid_lba got %0d want 0", sd.sd_lba); end
        repeat (2) @(negedge CLK_VIDEO);
        sd.sd_ack = 1'b0;
        repeat (10) begin
            @(negedge CLK_VIDEO);
            if (sd.sd_rd || sd.sd_wr || cpu_wait) moved = 1;
        end
        n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL rst_mid_advance got activity=%0b want 0", moved); end
    endtask

    task automatic test_track_change();
        track = 6'd5;
        pulse_mount();
        for (int i = 0; i < 13; i++) begin
            serve();
            if (i == 3) track = 6'd7;
            n_cmp++;
            if (r_to || r_wr !== 1'b0 || r_lba !== 32'(65 + i) || r_sec !== 4'(i)) begin
                n_bad++;
                $display("FAIL tc_load5[%0d] to=%0b wr=%0b lba=%0d sec=%0d want wr=0 lba=%0d sec=%0d",
                         i, r_to, r_wr, r_lba, r_sec, 65 + i, i);
            end
        end
        for (int i = 0; i < 13; i++) begin
            serve();
            n_cmp++;
            if (r_to || r_wr !== 1'b0 || r_lba !== 32'(91 + i) || r_sec !== 4'(i)) begin
                n_bad++;
                $display("FAIL tc_load7[%0d] to=%0b wr=%0b lba=%0d sec=%0d want wr=0 lba=%0d sec=%0d",
                         i, r_to, r_wr, r_lba, r_sec, 91 + i, i);
            end
        end
        @(negedge CLK_VIDEO);
        n_cmp++; if (cpu_wait !== 1'b0) begin n_bad++; $display("FAIL tc_wait_end got %0b want 0", cpu_wait); end
    endtask

    task automatic test_not_present();
        bit act = 0;
        img_present = 1'b0;
        track = 6'd9;
        pulse_mount();
        repeat (20) begin
            @(negedge CLK_VIDEO);
            if (sd.sd_rd || sd.sd_wr || cpu_wait) act = 1;
        end
        n_cmp++; if (act !== 1'b0) begin n_bad++; $display("FAIL np_activity got %0b want 0", act); end
        write_sec(14'h0200);
        @(negedge CLK_VIDEO);
        n_cmp++; if (dirty !== 13'd0) begin n_bad++; $display("FAIL np_dirty got %h want 0", dirty); end
    endtask

    initial begin
        sd.sd_ack = 1'b0;
        test_reset();
        test_mount_load();
        test_spurious_ack();
        test_writeback();
        test_readonly();
        test_reset_mid();
        test_track_change();
        test_not_present();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
